exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 45 ++++
 rtl/exec_ctrl_if.sv | 32 +++
 rtl/exec_ctrl_arg.sv | 31 +++
 rtl/exec_ctrl.sv | 142 ++++++++++++++
 tb/tb_exec_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg: controller states, opcode/compare constants and step sequencing helpers
package exec_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_OPCAP,
        S_DISPATCH,
        S_ARGREQ,
        S_ARGCAP,
        S_POP,
        S_EXEC,
        S_WB,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ICONST_0  = 8'h03;
    localparam logic [7:0] OP_BIPUSH    = 8'h10;
    localparam logic [7:0] OP_SIPUSH    = 8'h11;
    localparam logic [7:0] OP_IADD      = 8'h60;
    localparam logic [7:0] OP_IFEQ      = 8'h99;
    localparam logic [7:0] OP_IF_ICMPEQ = 8'h9F;
    localparam logic [7:0] OP_IF_ACMPNE = 8'hA6;
    localparam logic [7:0] OP_GOTO      = 8'hA7;
    localparam logic [7:0] OP_IRETURN   = 8'hAC;
    localparam logic [7:0] OP_ARETURN   = 8'hB0;
    localparam logic [7:0] OP_RETURN    = 8'hB1;

    function automatic logic is_return(logic [7:0] op);
        return op inside {OP_IRETURN, OP_ARETURN, OP_RETURN};
    endfunction

    // First step with work left in the ARG -> POP -> EXEC -> WB -> BRANCH chain;
    // callers zero the steps already completed.
    function automatic state_t next_step(logic [1:0] argc, logic [1:0] pops, logic alu, logic wb, logic br);
        return argc != 2'd0 ? S_ARGREQ :
               pops != 2'd0 ? S_POP    :
               alu          ? S_EXEC   :
               wb           ? S_WB     :
               br           ? S_BRANCH : S_FETCH;
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if: program memory, decoder, stack and ALU signals of the execution controller
//   master: controller side (drives pc, prog_en, opcode, arg, strobes)
//   slave : memory/decoder/stack/ALU side (drives prog_data, dec_*, alu_done, cmp_true)
interface exec_ctrl_if #(
    parameter int PC_W = 12
);
    logic [PC_W-1:0] pc;
    logic            prog_en;
    logic [7:0]      prog_data;
    logic [7:0]      opcode;
    logic [1:0]      dec_argc;
    logic [1:0]      dec_stackargs;
    logic            dec_stackwb;
    logic            dec_isaluop;
    logic            dec_iscmp;
    logic [15:0]     arg;
    logic            stk_pop;
    logic            stk_push;
    logic            alu_start;
    logic            alu_done;
    logic            cmp_true;

    modport master (
        output pc, prog_en, opcode, arg, stk_pop, stk_push, alu_start,
        input  prog_data, dec_argc, dec_stackargs, dec_stackwb, dec_isaluop, dec_iscmp, alu_done, cmp_true
    );

    modport slave (
        input  pc, prog_en, opcode, arg, stk_pop, stk_push, alu_start,
        output prog_data, dec_argc, dec_stackargs, dec_stackwb, dec_isaluop, dec_iscmp, alu_done, cmp_true
    );
endinterface

// File: rtl/exec_ctrl_arg.sv
// prog_arg_fetch: inline-argument byte counter and big-endian shift register
//   clr  : clear arg and load argc (dispatch)
//   cap  : shift prog_data into arg (one per argument byte)
//   last : the byte being captured is the final one
module prog_arg_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [1:0]  argc,
    input  logic        cap,
    input  logic [7:0]  data,
    output logic [15:0] arg,
    output logic        last
);
    logic [1:0] rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arg <= '0;
            rem <= '0;
        end else if (clr) begin
            arg <= '0;
            rem <= argc;
        end else if (cap) begin
            arg <= {arg[7:0], data};
            rem <= rem - 2'd1;
        end
    end

    assign last = rem == 2'd1;
endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: bytecode execution controller sequencing fetch, args, pops, ALU, writeback and branch
//   clk, rst_n (async active-low), start (leave IDLE/HALT, fetch from 0)
//   bus    : exec_ctrl_if.master (program memory, decoder, stack, ALU, comparator)
//   busy   : not IDLE/HALT;  halted : in HALT
//   BRANCH_EN : when defined, compare/GOTO opcodes take branches in a BRANCH state
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    exec_ctrl_if.master bus,
    output logic        busy,
    output logic        halted
);
    state_t          state, state_d;
    logic [PC_W-1:0] pc, pc_d, op_addr, op_addr_d;
    logic [7:0]      opcode, opcode_d;
    logic [1:0]      pops, pops_d;
    logic            alu_f, alu_d, wb_f, wb_d, br_f, br_d;
    logic            exec_wait, prog_en, arg_clr, arg_cap, arg_last;
    logic [15:0]     arg;

    prog_arg_fetch u_arg (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (arg_clr),
        .argc (bus.dec_argc),
        .cap  (arg_cap),
        .data (bus.prog_data),
        .arg  (arg),
        .last (arg_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            op_addr   <= '0;
            opcode    <= '0;
            pops      <= '0;
            alu_f     <= 1'b0;
            wb_f      <= 1'b0;
            br_f      <= 1'b0;
            exec_wait <= 1'b0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            op_addr   <= op_addr_d;
            opcode    <= opcode_d;
            pops      <= pops_d;
            alu_f     <= alu_d;
            wb_f      <= wb_d;
            br_f      <= br_d;
            // EXEC is never re-entered directly, so this marks "not the entry cycle"
            exec_wait <= state == S_EXEC;
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        op_addr_d = op_addr;
        opcode_d  = opcode;
        pops_d    = pops;
        alu_d     = alu_f;
        wb_d      = wb_f;
        br_d      = br_f;
        prog_en   = 1'b0;
        arg_clr   = 1'b0;
        arg_cap   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                state_d = start ? S_FETCH : state;
                pc_d    = start ? '0 : pc;
            end
            S_FETCH: begin
                prog_en   = 1'b1;
                op_addr_d = pc;
                state_d   = S_OPCAP;
            end
            S_OPCAP: begin
                opcode_d = bus.prog_data;
                pc_d     = pc + 1'b1;
                state_d  = S_DISPATCH;
            end
            S_DISPATCH: begin
                arg_clr = 1'b1;
                pops_d  = bus.dec_stackargs;
                alu_d   = bus.dec_isaluop;
                wb_d    = bus.dec_stackwb;
`ifdef BRANCH_EN
                br_d    = bus.dec_iscmp || opcode == OP_GOTO;
`else
                br_d    = 1'b0;
`endif
                state_d = is_return(opcode) ? S_HALT :
                          next_step(bus.dec_argc, bus.dec_stackargs, bus.dec_isaluop, bus.dec_stackwb, br_d);
            end
            S_ARGREQ: begin
                prog_en = 1'b1;
                state_d = S_ARGCAP;
            end
            S_ARGCAP: begin
                arg_cap = 1'b1;
                pc_d    = pc + 1'b1;
                state_d = arg_last ? next_step(2'd0, pops, alu_f, wb_f, br_f) : S_ARGREQ;
            end
            S_POP: begin
                pops_d  = pops - 2'd1;
                state_d = pops == 2'd1 ? next_step(2'd0, 2'd0, alu_f, wb_f, br_f) : S_POP;
            end
            S_EXEC:  state_d = bus.alu_done ? next_step(2'd0, 2'd0, 1'b0, wb_f, br_f) : S_EXEC;
            S_WB:    state_d = next_step(2'd0, 2'd0, 1'b0, 1'b0, br_f);
`ifdef BRANCH_EN
            S_BRANCH: begin
                // 32-bit sign extension then truncation gives the modulo-2^PC_W target
                pc_d    = (opcode == OP_GOTO || bus.cmp_true) ? op_addr + PC_W'(32'($signed(arg))) : pc;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifndef BRANCH_EN
    logic unused_nobranch;
    assign unused_nobranch = bus.cmp_true ^ (^op_addr);
`endif

    assign bus.pc        = pc;
    assign bus.prog_en   = prog_en;
    assign bus.opcode    = opcode;
    assign bus.arg       = arg;
    assign bus.stk_pop   = state == S_POP;
    assign bus.stk_push  = state == S_WB;
    assign bus.alu_start = state == S_EXEC && !exec_wait;
    assign busy          = !(state inside {S_IDLE, S_HALT});
    assign halted        = state == S_HALT;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: randomized self-checking bench against a per-instruction behavioural model
module tb_exec_ctrl;
    localparam int PC_W = 12;
`ifdef BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start, busy, halted;

    exec_ctrl_if #(.PC_W(PC_W)) bus ();

    exec_ctrl #(.PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .halted(halted)
    );

    logic [7:0]      mem [0:(1<<PC_W)-1];
    logic [PC_W-1:0] ipc;
    logic [15:0]     exp_arg;
    int              checks = 0;
    int              errors = 0;
    bit              first_alu, br_alt, br_tog;

    always #5 clk = ~clk;

    // {argc[1:0], stackargs[1:0], stackwb, isaluop, iscmp}
    function automatic logic [6:0] dec(logic [7:0] op);
        case (op)
            8'h03:        return 7'b00_00_100;
            8'h10:        return 7'b01_00_100;
            8'h11:        return 7'b10_00_100;
            8'h60:        return 7'b00_10_110;
            8'h9F:        return 7'b10_10_001;
            8'hA7:        return 7'b10_00_000;
            8'h57:        return 7'b00_01_000;
            8'hCA:        return 7'b01_11_010;
            8'hAC, 8'hB0: return 7'b00_01_000;
            default:      return 7'b00_00_000;
        endcase
    endfunction

    always_comb {bus.dec_argc, bus.dec_stackargs, bus.dec_stackwb, bus.dec_isaluop, bus.dec_iscmp} = dec(bus.opcode);

    always @(posedge clk) if (bus.prog_en) bus.prog_data <= mem[bus.pc];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One busy cycle: expected program strobe/address and stack/ALU strobes.
    task automatic cyc(input bit pe, input logic [PC_W-1:0] epc, input bit pop, input bit push, input bit ast, input int ad);
        @(negedge clk);
        start = ($urandom_range(0, 7) == 0);
        bus.cmp_true = 1'($urandom_range(0, 1));
        bus.alu_done = ad < 0 ? 1'($urandom_range(0, 1)) : ad[0];
        check("prog_en", 32'(bus.prog_en), 32'(pe));
        if (pe) check("pc", 32'(bus.pc), 32'(epc));
        check("stk_pop", 32'(bus.stk_pop), 32'(pop));
        check("stk_push", 32'(bus.stk_push), 32'(push));
        check("alu_start", 32'(bus.alu_start), 32'(ast));
        check("busy", 32'(busy), 32'd1);
        check("halted", 32'(halted), 32'd0);
    endtask

    task automatic idle_chk(input bit h, input int ad);
        @(negedge clk);
        start = 1'b0;
        bus.alu_done = ad < 0 ? 1'($urandom_range(0, 1)) : ad[0];
        check("idle_prog_en", 32'(bus.prog_en), 32'd0);
        check("idle_stk_pop", 32'(bus.stk_pop), 32'd0);
        check("idle_stk_push", 32'(bus.stk_push), 32'd0);
        check("idle_alu_start", 32'(bus.alu_start), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_halted", 32'(halted), 32'(h));
    endtask

    task automatic rst_chk();
        check("rst_pc", 32'(bus.pc), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_arg", 32'(bus.arg), 32'd0);
        check("rst_prog_en", 32'(bus.prog_en), 32'd0);
        check("rst_stk_pop", 32'(bus.stk_pop), 32'd0);
        check("rst_stk_push", 32'(bus.stk_push), 32'd0);
        check("rst_alu_start", 32'(bus.alu_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        bus.alu_done = 1'b0;
        #1;
        rst_chk();
        @(negedge clk);
        rst_n = 1'b1;
        exp_arg = '0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        bus.alu_done = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        ipc = '0;
    endtask

    // Expected cycle sequence of one instruction derived from its decoder counts.
    task automatic run_instr(output bit hlt);
        logic [7:0]      op;
        logic [1:0]      argc, pops;
        logic            wb, alu, cmp;
        logic [15:0]     a;
        logic [PC_W-1:0] ba, nxt;
        int              lat;
        op = mem[ipc];
        {argc, pops, wb, alu, cmp} = dec(op);
        cyc(1'b1, ipc, 1'b0, 1'b0, 1'b0, -1);
        check("arg", 32'(bus.arg), 32'(exp_arg));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
        check("opcode", 32'(bus.opcode), 32'(op));
        hlt = 1'b0;
        if (op == 8'hB1 || op == 8'hAC || op == 8'hB0) begin
            idle_chk(1'b1, -1);
            check("halt_arg", 32'(bus.arg), 32'd0);
            exp_arg = '0;
            hlt = 1'b1;
            return;
        end
        a = '0;
        for (int i = 0; i < int'(argc); i++) begin
            ba = PC_W'(int'(ipc) + 1 + i);
            cyc(1'b1, ba, 1'b0, 1'b0, 1'b0, -1);
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
            a = {a[7:0], mem[ba]};
        end
        for (int i = 0; i < int'(pops); i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, -1);
        if (alu) begin
            lat = first_alu ? 4 : int'($urandom_range(0, 4));
            first_alu = 1'b0;
            for (int k = 0; k <= lat; k++) cyc(1'b0, '0, 1'b0, 1'b0, k == 0, int'(k == lat));
        end
        if (wb) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, -1);
        nxt = PC_W'(int'(ipc) + 1 + int'(argc));
        if (BR && (cmp || op == 8'hA7)) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
            if (br_alt) begin
                bus.cmp_true = br_tog;
                br_tog = ~br_tog;
            end
            if (op == 8'hA7 || bus.cmp_true) nxt = PC_W'(int'(ipc) + int'($signed(a)));
        end
        exp_arg = a;
        ipc = nxt;
    endtask

    task automatic run_prog(input int n);
        bit h;
        do_start();
        for (int i = 0; i < n; i++) begin
            run_instr(h);
            if (h) do_start();
        end
    endtask

    initial begin
        logic [7:0] ops [13] = '{8'h00, 8'h03, 8'h10, 8'h11, 8'h60, 8'h9F, 8'hA7, 8'h57, 8'hCA, 8'hB1, 8'hAC, 8'hB0, 8'h00};
        rst_n = 1'b1;
        start = 1'b0;
        bus.alu_done = 1'b0;
        bus.cmp_true = 1'b0;
        exp_arg = '0;
        first_alu = 1'b1;
        br_alt = 1'b1;
        br_tog = 1'b1;
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_chk();
        rst_n = 1'b1;

        // Directed program: NOP, BIPUSH, SIPUSH, ICONST_0, IADD, unlisted, POP, IF_ICMPEQ loop, GOTO wrap
        mem[12'h001] = 8'h10; mem[12'h002] = 8'h85;
        mem[12'h003] = 8'h11; mem[12'h004] = 8'h12; mem[12'h005] = 8'h34;
        mem[12'h006] = 8'h03;
        mem[12'h007] = 8'h60;
        mem[12'h008] = 8'hCA; mem[12'h009] = 8'h55;
        mem[12'h00A] = 8'h57;
        mem[12'h010] = 8'h9F; mem[12'h011] = 8'hFF; mem[12'h012] = 8'hF8;
        mem[12'h013] = 8'hA7; mem[12'h014] = 8'h0F; mem[12'h015] = 8'hEC;
        mem[12'h016] = 8'hB1;
        mem[12'hFFF] = 8'hA7;
        run_prog(60);

        // Reset in the middle of an ALU wait; a late alu_done must not resume anything
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = 8'h00;
        mem[12'h000] = 8'h60;
        mem[12'h001] = 8'hB1;
        do_reset();
        do_start();
        cyc(1'b1, '0, 1'b0, 1'b0, 1'b0, -1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, -1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, -1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, -1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
        do_reset();
        repeat (4) idle_chk(1'b0, 1);
        run_prog(3);

        // Random programs with random branch outcomes and ALU latencies
        br_alt = 1'b0;
        for (int i = 0; i < (1 << PC_W); i++) begin
            int j;
            j = int'($urandom_range(0, 13));
            mem[i] = j == 13 ? 8'($urandom) : ops[j];
        end
        do_reset();
        run_prog(250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
